// File: rtl/pcm_to_i2s.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s
//
// I2S master transmitter. Takes stereo PCM pairs through a valid/ready
// handshake with a one-pair holding register. Generates SCK and WS from clk.
// Shifts the samples out MSB first on SD, using the standard I2S one-bit
// delay after each WS edge.
//
// Parameters
//   NUMBER_OF_BITS : PCM sample width per channel
//   SLOT_BITS      : SCK cycles per channel slot; must be >= NUMBER_OF_BITS+1
//   CLK_DIV        : clk cycles per SCK half-period; must be >= 1
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   enable       in   start/continue framing; stops at a frame boundary when low
//   in_valid     in   in_left/in_right hold a valid pair
//   in_ready     out  holding register empty (registered)
//   in_left      in   left sample, two's complement
//   in_right     in   right sample, two's complement
//   sck          out  I2S bit clock
//   ws           out  word select: 0 = left slot, 1 = right slot
//   sd           out  serial data, changes only on SCK falling edges
//   frame_start  out  1-clk pulse when a new frame (left slot, bit 0) begins
//   underflow    out  1-clk pulse when a frame starts with no pair held
//   state_dbg    out  current FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS      = 16,
    parameter int CLK_DIV        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      frame_start,
    output logic                      underflow,
    output logic                      state_dbg
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int KW    = $clog2(SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [KW-1:0]    K_LAST      = KW'(SLOT_BITS - 1);
    localparam logic [KW-1:0]    K_DATA_LAST = KW'(NUMBER_OF_BITS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [DIV_W-1:0]          div_q, div_d;
    logic                      sck_q, sck_d;
    logic                      ws_q, ws_d;
    logic                      sd_q, sd_d;
    logic                      slot_q, slot_d;       // 0 = left, 1 = right
    logic [KW-1:0]             k_q, k_d;             // bit position within slot
    logic                      started_q, started_d; // at least one frame begun since RUN entry
    logic [NUMBER_OF_BITS-1:0] shift_l_q, shift_l_d;
    logic [NUMBER_OF_BITS-1:0] shift_r_q, shift_r_d;
    logic [NUMBER_OF_BITS-1:0] hold_l_q, hold_l_d;
    logic [NUMBER_OF_BITS-1:0] hold_r_q, hold_r_d;
    logic                      hold_full_q, hold_full_d;
    logic                      in_ready_q, in_ready_d;
    logic                      frame_start_q, frame_start_d;
    logic                      underflow_q, underflow_d;

    logic accept;
    logic at_boundary;

    // Handshake: a pair is taken on any clk edge where in_valid && in_ready.
    // in_ready is a register equal to "holding register empty after this
    // edge". It therefore drops on the accept edge and rises on the edge that
    // moves the pair into the shift registers. Accept and transfer can never
    // coincide, because a transfer needs a full register, and then in_ready is 0.
    assign accept = in_valid && in_ready_q;

    // The next fall event starts a new frame. This holds either on the first
    // fall event after entering RUN, or after the last bit of the right slot.
    assign at_boundary = !started_q || (slot_q && (k_q == K_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            sck_q         <= 1'b0;
            ws_q          <= 1'b1;
            sd_q          <= 1'b0;
            slot_q        <= 1'b0;
            k_q           <= '0;
            started_q     <= 1'b0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
            hold_l_q      <= '0;
            hold_r_q      <= '0;
            hold_full_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            sck_q         <= sck_d;
            ws_q          <= ws_d;
            sd_q          <= sd_d;
            slot_q        <= slot_d;
            k_q           <= k_d;
            started_q     <= started_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            hold_l_q      <= hold_l_d;
            hold_r_q      <= hold_r_d;
            hold_full_q   <= hold_full_d;
            in_ready_q    <= in_ready_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        sck_d         = sck_q;
        ws_d          = ws_q;
        sd_d          = sd_q;
        slot_d        = slot_q;
        k_d           = k_q;
        started_d     = started_q;
        shift_l_d     = shift_l_q;
        shift_r_d     = shift_r_q;
        hold_l_d      = hold_l_q;
        hold_r_d      = hold_r_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        underflow_d   = 1'b0;

        if (accept) begin
            hold_l_d    = in_left;
            hold_r_d    = in_right;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                sck_d     = 1'b0;
                ws_d      = 1'b1;
                sd_d      = 1'b0;
                div_d     = '0;
                slot_d    = 1'b0;
                k_d       = '0;
                started_d = 1'b0;
                if (enable) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    // sck currently high: this edge is a fall event
                    if (sck_q) begin
                        if (at_boundary) begin
                            if (enable) begin
                                started_d     = 1'b1;
                                slot_d        = 1'b0;
                                k_d           = '0;
                                ws_d          = 1'b0;
                                sd_d          = 1'b0;
                                frame_start_d = 1'b1;
                                if (hold_full_q) begin
                                    shift_l_d   = hold_l_q;
                                    shift_r_d   = hold_r_q;
                                    hold_full_d = 1'b0;
                                end else begin
                                    shift_l_d   = '0;
                                    shift_r_d   = '0;
                                    underflow_d = 1'b1;
                                end
                            end else begin
                                // Frame finished with enable low: park in IDLE
                                state_d   = ST_IDLE;
                                started_d = 1'b0;
                                slot_d    = 1'b0;
                                k_d       = '0;
                                ws_d      = 1'b1;
                                sd_d      = 1'b0;
                            end
                        end else if (k_q == K_LAST) begin
                            // End of the left slot (right-slot end is a boundary)
                            slot_d = 1'b1;
                            k_d    = '0;
                            ws_d   = 1'b1;
                            sd_d   = 1'b0;
                        end else begin
                            k_d = k_q + 1'b1;
                            // New k in 1..NUMBER_OF_BITS carries data, MSB first
                            if (k_q < K_DATA_LAST) begin
                                if (!slot_q) begin
                                    sd_d      = shift_l_q[NUMBER_OF_BITS-1];
                                    shift_l_d = shift_l_q << 1;
                                end else begin
                                    sd_d      = shift_r_q[NUMBER_OF_BITS-1];
                                    shift_r_d = shift_r_q << 1;
                                end
                            end else begin
                                sd_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d = !hold_full_d;
    end

    assign in_ready    = in_ready_q;
    assign sck         = sck_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// ---------------------------------------------------------------------------
// tb_pcm_to_i2s
//
// Self-checking bench for pcm_to_i2s with NUMBER_OF_BITS=8, SLOT_BITS=16,
// CLK_DIV=2 (SCK = 4 clk, frame = 128 clk).
//
// Each accepted pair pushes its expected 32-bit SD sequence onto exp_q. The
// sequence is left slot k=0..15, then right slot k=0..15, one bit per SCK
// rise. A monitor acts as a receiver: at each frame_start it pops the next
// expected sequence, or expects an underflow frame of zeros when none is
// pending. It then collects 32 SD/WS bits at the SCK rises and compares them.
// ---------------------------------------------------------------------------
module tb_pcm_to_i2s;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_left;
    logic [7:0] in_right;
    logic       sck;
    logic       ws;
    logic       sd;
    logic       frame_start;
    logic       underflow;
    logic       state_dbg;

    logic [31:0] drv_exp;
    logic [31:0] exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_done = 0;
    int uf_frames = 0;
    int last_acc_cyc = 0;
    bit mon_active = 0;

    typedef struct {
        logic [7:0]  left;
        logic [7:0]  right;
        logic [15:0] exp_left_slot;
        logic [15:0] exp_right_slot;
    } vec_t;

    vec_t vecs[6];

    pcm_to_i2s #(
        .NUMBER_OF_BITS(8),
        .SLOT_BITS(16),
        .CLK_DIV(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_left(in_left),
        .in_right(in_right),
        .sck(sck),
        .ws(ws),
        .sd(sd),
        .frame_start(frame_start),
        .underflow(underflow),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_seq(input logic [7:0] l, input logic [7:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // Drives a pair from posedge+1 and holds it until the DUT takes it
    task automatic send_pair(input logic [7:0] l, input logic [7:0] r, input logic [31:0] e);
        int n;
        @(posedge clk);
        #1;
        in_left  = l;
        in_right = r;
        drv_exp  = e;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_wait", (n < 400), 1);
        if (n < 400) begin
            @(posedge clk);
            #1;
            last_acc_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_frame_start(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_start !== 1'b1 && n < 400);
        chk(name, frame_start, 1);
    endtask

    task automatic wait_frames(input int target, input string name);
        int n;
        n = 0;
        while (frames_done < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (frames_done >= target), 1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while ((exp_q.size() != 0 || mon_active) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < 5000), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [31:0] cur_exp;
        logic [31:0] got_bits;
        logic [31:0] ws_bits;
        logic [31:0] acc_data;
        int          nbits;
        logic        sck_prev;
        logic        acc_next;
        cur_exp  = '0;
        got_bits = '0;
        ws_bits  = '0;
        acc_data = '0;
        nbits    = 0;
        sck_prev = 1'b0;
        acc_next = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_active = 0;
                exp_q.delete();
                acc_next = 1'b0;
                sck_prev = 1'b0;
            end else begin
                // A frame start on the same edge as an accept sees the
                // register empty, so frame starts are handled first.
                if (frame_start) begin
                    if (mon_active) chk("frame_cut_short", nbits, 32);
                    chk("underflow_flag", underflow, (exp_q.size() == 0));
                    if (exp_q.size() > 0) begin
                        cur_exp = exp_q.pop_front();
                    end else begin
                        cur_exp = '0;
                        uf_frames++;
                    end
                    mon_active = 1;
                    nbits      = 0;
                    got_bits   = '0;
                    ws_bits    = '0;
                end
                if (acc_next) exp_q.push_back(acc_data);
                if (sck && !sck_prev && mon_active) begin
                    got_bits = {got_bits[30:0], sd};
                    ws_bits  = {ws_bits[30:0], ws};
                    nbits++;
                    if (nbits == 32) begin
                        chk("frame_data", got_bits, cur_exp);
                        chk("frame_ws", ws_bits, 32'h0000FFFF);
                        mon_active = 0;
                        frames_done++;
                    end
                end
                sck_prev = sck;
                acc_next = in_valid && in_ready;
                acc_data = drv_exp;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int acc_cyc[6];
        int idle_bad;
        int u0;
        int fr;
        logic [3:0] lat;
        logic [7:0] rl;
        logic [7:0] rr;

        vecs[0] = '{8'hA5, 8'h3C, 16'h5280, 16'h1E00};
        vecs[1] = '{8'h80, 8'h01, 16'h4000, 16'h0080};
        vecs[2] = '{8'hFF, 8'h00, 16'h7F80, 16'h0000};
        vecs[3] = '{8'h7F, 8'hFE, 16'h3F80, 16'h7F00};
        vecs[4] = '{8'h01, 8'h80, 16'h0080, 16'h4000};
        vecs[5] = '{8'h5A, 8'hC3, 16'h2D00, 16'h6180};

        rst_n    = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        drv_exp  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset_outputs", {sck, ws, sd, in_ready, frame_start, underflow}, 6'b010000);
        chk("reset_state", state_dbg, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_release", in_ready, 1);
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (sck !== 1'b0 || ws !== 1'b1 || sd !== 1'b0 || frame_start !== 1'b0) idle_bad++;
        end
        chk("idle_static", idle_bad, 0);

        // Table vectors, back-to-back under back-pressure
        for (int i = 0; i < 6; i++) begin
            send_pair(vecs[i].left, vecs[i].right, {vecs[i].exp_left_slot, vecs[i].exp_right_slot});
            acc_cyc[i] = last_acc_cyc;
            if (i == 0) begin
                chk("in_ready_low_when_full", in_ready, 0);
                enable = 1'b1;
                wait_frame_start("first_frame_start");
                chk("first_no_underflow", underflow, 0);
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    lat[3-j] = sd;
                end
                chk("msb_latency", lat, 4'b0001);
            end
            if (i >= 3) chk("accept_spacing", acc_cyc[i] - acc_cyc[i-1], 128);
        end
        wait_frames(6, "table_frames");
        chk("table_queue_empty", exp_q.size(), 0);

        // Underflow with no pair, then refill mid-frame
        u0 = uf_frames;
        wait_frames(frames_done + 1, "underflow_frame");
        chk("underflow_seen", (uf_frames > u0), 1);
        wait_frame_start("uf_frame_start");
        chk("uf_pulse_with_frame_start", underflow, 1);
        repeat (40) @(negedge clk);
        u0 = uf_frames;
        fr = frames_done;
        send_pair(8'h96, 8'h69, 32'h4B00_3480);
        wait_frames(fr + 2, "refill_frames");
        chk("refill_no_underflow", uf_frames, u0);

        // Stop mid-left-slot
        wait_frame_start("pre_stop_frame_start");
        send_pair(8'hC6, 8'h1B, 32'h6300_0D80);
        wait_frame_start("stop_frame_start");
        fr = frames_done;
        repeat (20) @(negedge clk);
        chk("stop_in_left_slot", ws, 0);
        enable = 1'b0;
        wait_frames(fr + 1, "stop_frame_completes");
        repeat (4) @(negedge clk);
        idle_bad = 0;
        repeat (24) begin
            @(negedge clk);
            if (sck !== 1'b0 || ws !== 1'b1 || sd !== 1'b0 || frame_start !== 1'b0 || state_dbg !== 1'b0)
                idle_bad++;
        end
        chk("stopped_idle", idle_bad, 0);

        // Re-enable
        enable = 1'b1;
        fr = frames_done;
        send_pair(8'h2E, 8'hD1, 32'h1700_6880);
        wait_frame_start("reenable_frame_start");
        chk("reenable_no_underflow", underflow, 0);
        wait_frames(fr + 1, "reenable_frame");

        // Loopback with random pairs
        for (int i = 0; i < 8; i++) begin
            rl = 8'($urandom_range(0, 255));
            rr = 8'($urandom_range(0, 255));
            send_pair(rl, rr, model_seq(rl, rr));
        end
        wait_drain("random_drain");

        // Reset mid-frame with a pair held
        send_pair(8'hFF, 8'hFF, 32'h7F80_7F80);
        wait_frame_start("pre_reset_frame_start");
        send_pair(8'h5A, 8'hC3, 32'h2D00_6180);
        repeat (20) @(negedge clk);
        chk("pre_reset_state", {ws, sd, in_ready}, 3'b010);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("reset_midframe_outputs", {sck, ws, sd, in_ready, frame_start, underflow}, 6'b010000);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_frame_start("post_reset_frame_start");
        chk("held_pair_discarded", underflow, 1);
        enable = 1'b0;
        wait_drain("final_drain");
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
